// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Exports: op_e (funct3 codes), state_e (FSM states), XLEN, DIV0_QUO, INT_MIN, neg32().
// Pure declarations; no logic, no latency, no flow control.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Two's complement negation, modulo 2^32.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// master: pipeline side (drives request, flush, res_ready); slave: the unit (drives ready/busy/valid/result/rd).
// Request accepted on i_start & o_ready; result held on o_valid until i_res_ready.
interface muldiv_seq_if;
    import muldiv_pkg::*;

    logic            i_start;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic [4:0]      i_rd;
    logic            i_flush;
    logic            o_ready;
    logic            o_busy;
    logic            o_valid;
    logic            i_res_ready;
    logic [XLEN-1:0] o_result;
    logic [4:0]      o_rd;

    modport master (
        output i_start, i_op, i_rs1, i_rs2, i_rd, i_flush, i_res_ready,
        input  o_ready, o_busy, o_valid, o_result, o_rd
    );

    modport slave (
        input  i_start, i_op, i_rs1, i_rs2, i_rd, i_flush, i_res_ready,
        output o_ready, o_busy, o_valid, o_result, o_rd
    );

endinterface

// File: rtl/muldiv_addsub.sv
// Shared 32-bit adder/subtractor with carry-out; used by both shift-add and shift-subtract steps.
// Ports: a, b operands; sub selects a-b (carry-out 1 means no borrow); sum, cout results.
// Purely combinational, zero latency, no flow control.
module muldiv_addsub
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sub,
    output logic [XLEN-1:0] sum,
    output logic            cout
);

    logic [XLEN:0] full;

    // Subtraction as a + ~b + 1 so one carry chain serves both directions.
    assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{XLEN{1'b0}}, sub};
    assign sum  = full[XLEN-1:0];
    assign cout = full[XLEN];

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit, one add/sub per cycle.
// Latency: 34 cycles from start to o_valid (1 cycle for divide-by-zero and signed overflow).
// Backpressure: o_ready only in IDLE; result held in DONE until i_res_ready; i_flush aborts anywhere.
// Ports: clk, rst (async, active high), bus (muldiv_seq_if.slave: request, flush, result handshake).
module muldiv_seq #(
    parameter int XLEN = 32,   // only 32 is supported
    parameter int ITER = XLEN
) (
    input logic        clk,
    input logic        rst,
    muldiv_seq_if.slave bus
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_e          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [XLEN-1:0] hi, hi_n;       // MUL: product high word; DIV: partial remainder
    logic [XLEN-1:0] lo, lo_n;       // MUL: multiplier/product low word; DIV: dividend/quotient
    logic [XLEN-1:0] opnd, opnd_n;   // MUL: |A| added each step; DIV: |B| subtracted each step
    op_e             op, op_n;
    logic [4:0]      rd, rd_n;
    logic            sa, sa_n;
    logic            sb, sb_n;
    logic [XLEN-1:0] result, result_n;

    // Request decode
    op_e             req_op;
    logic            req_div;
    logic            req_sa, req_sb;
    logic [XLEN-1:0] mag_a, mag_b;

    // Datapath
    logic            is_div;
    logic [XLEN-1:0] add_a, add_sum;
    logic            add_cout;
    logic [2*XLEN-1:0] prod, prod_adj;
    logic [XLEN-1:0] quo_adj, rem_adj;

    assign req_op  = op_e'(bus.i_op);
    assign req_div = bus.i_op[2];

    // Sign flags are only set for operands treated as signed, so the
    // later correction is simply sa^sb (quotient/product) or sa (remainder).
    always_comb begin
        req_sa = 1'b0;
        req_sb = 1'b0;
        case (req_op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                req_sa = bus.i_rs1[XLEN-1];
                req_sb = bus.i_rs2[XLEN-1];
            end
            OP_MULHSU: req_sa = bus.i_rs1[XLEN-1];
            default: ;
        endcase
    end

    assign mag_a = req_sa ? neg32(bus.i_rs1) : bus.i_rs1;
    assign mag_b = req_sb ? neg32(bus.i_rs2) : bus.i_rs2;

    // DIV steps trial-subtract from the remainder shifted left with the next
    // dividend bit; MUL steps add |A| into the high word.
    assign is_div = op[2];
    assign add_a  = is_div ? {hi[XLEN-2:0], lo[XLEN-1]} : hi;

    muldiv_addsub u_addsub (
        .a    (add_a),
        .b    (opnd),
        .sub  (is_div),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign prod     = {hi, lo};
    assign prod_adj = (sa ^ sb) ? (~prod + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod;
    assign quo_adj  = (sa ^ sb) ? neg32(lo) : lo;
    assign rem_adj  = sa ? neg32(hi) : hi;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hi_n     = hi;
        lo_n     = lo;
        opnd_n   = opnd;
        op_n     = op;
        rd_n     = rd;
        sa_n     = sa;
        sb_n     = sb;
        result_n = result;

        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    op_n  = req_op;
                    rd_n  = bus.i_rd;
                    sa_n  = req_sa;
                    sb_n  = req_sb;
                    cnt_n = '0;
                    if (req_div && (bus.i_rs2 == '0)) begin
                        result_n = bus.i_op[1] ? bus.i_rs1 : DIV0_QUO;
                        state_n  = DONE;
                    end else if (req_div && !bus.i_op[0] &&
                                 (bus.i_rs1 == INT_MIN) && (bus.i_rs2 == '1)) begin
                        result_n = bus.i_op[1] ? '0 : INT_MIN;
                        state_n  = DONE;
                    end else begin
                        hi_n    = '0;
                        lo_n    = req_div ? mag_a : mag_b;
                        opnd_n  = req_div ? mag_b : mag_a;
                        state_n = CALC;
                    end
                end
            end

            CALC: begin
                if (is_div) begin
                    // A set bit shifted out of the remainder means it already exceeds |B|.
                    if (hi[XLEN-1] || add_cout) begin
                        hi_n = add_sum;
                        lo_n = {lo[XLEN-2:0], 1'b1};
                    end else begin
                        hi_n = add_a;
                        lo_n = {lo[XLEN-2:0], 1'b0};
                    end
                end else begin
                    if (lo[0]) begin
                        hi_n = {add_cout, add_sum[XLEN-1:1]};
                        lo_n = {add_sum[0], lo[XLEN-1:1]};
                    end else begin
                        hi_n = {1'b0, hi[XLEN-1:1]};
                        lo_n = {hi[0], lo[XLEN-1:1]};
                    end
                end
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = ADJ;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            ADJ: begin
                case (op)
                    OP_MUL:                       result_n = prod_adj[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_n = prod_adj[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:              result_n = quo_adj;
                    default:                      result_n = rem_adj;
                endcase
                state_n = DONE;
            end

            DONE: begin
                if (bus.i_res_ready) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase

        // Flush wins over both start and result handoff.
        if (bus.i_flush) begin
            state_n = IDLE;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            op     <= OP_MUL;
            rd     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            hi     <= hi_n;
            lo     <= lo_n;
            opnd   <= opnd_n;
            op     <= op_n;
            rd     <= rd_n;
            sa     <= sa_n;
            sb     <= sb_n;
            result <= result_n;
        end
    end

    assign bus.o_ready  = (state == IDLE);
    assign bus.o_busy   = (state != IDLE);
    assign bus.o_valid  = (state == DONE);
    assign bus.o_result = result;
    assign bus.o_rd     = rd;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, random ops against an arithmetic model,
// and hand sequences for flush, result backpressure, ignored starts and asynchronous reset.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_seq_if bus();

    muldiv_seq #(.XLEN(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the RISC-V special-case rules.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; return 32'(sa / sb); end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; return 32'(sa % sb); end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Waits for ready, issues one request, returns result/tag and cycles until o_valid.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rd_o, output int lat);
        int guard;
        guard = 0;
        while (!bus.o_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.i_op    = op;
        bus.i_rs1   = a;
        bus.i_rs2   = b;
        bus.i_rd    = rd;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        lat = 1;
        while (!bus.o_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res  = bus.o_result;
        rd_o = bus.o_rd;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] res, held;
        logic [4:0]  rd_o;
        int          lat;
        int          seen;

        tbl[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3"};
        tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff"};
        tbl[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ff"};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff"};
        tbl[4]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ff"};
        tbl[5]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_-7/2"};
        tbl[6]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_-7/2"};
        tbl[7]  = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, "divu_f9/2"};
        tbl[8]  = '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, "remu_f9/2"};
        tbl[9]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divu_5/0"};
        tbl[10] = '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "rem_5/0"};
        tbl[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"};
        tbl[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"};

        bus.i_start     = 1'b0;
        bus.i_op        = 3'd0;
        bus.i_rs1       = '0;
        bus.i_rs2       = '0;
        bus.i_rd        = '0;
        bus.i_flush     = 1'b0;
        bus.i_res_ready = 1'b1;
        rst             = 1'b1;

        // Reset state
        wait_cycles(2);
        check("rst_ready",  32'(bus.o_ready),  32'd1);
        check("rst_busy",   32'(bus.o_busy),   32'd0);
        check("rst_valid",  32'(bus.o_valid),  32'd0);
        check("rst_result", bus.o_result,      32'd0);
        check("rst_rd",     32'(bus.o_rd),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(1);

        // Directed vectors: result, echoed tag, start-to-valid latency
        for (int i = 0; i < 13; i++) begin
            logic [4:0] tag;
            tag = (i == 0) ? 5'd12 : 5'(i + 3);
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tag, res, rd_o, lat);
            check({tbl[i].name, "_result"}, res, tbl[i].exp);
            check({tbl[i].name, "_rd"}, 32'(rd_o), 32'(tag));
            check({tbl[i].name, "_latency"}, 32'(lat), 32'(ref_latency(tbl[i].op, tbl[i].a, tbl[i].b)));
        end

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            logic [4:0]  tag;
            int          sel;
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            tag = 5'($urandom_range(0, 31));
            sel = $urandom_range(0, 9);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            else if (sel == 3) b = -32'($urandom_range(1, 15));
            run_op(op, a, b, tag, res, rd_o, lat);
            check($sformatf("rand%0d_op%0d_result", i, op), res, ref_result(op, a, b));
            check($sformatf("rand%0d_rd", i), 32'(rd_o), 32'(tag));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_latency(op, a, b)));
        end

        // Flush in the middle of CALC: no result, ready right after
        wait_cycles(1);
        bus.i_op = 3'd4; bus.i_rs1 = 32'd1000; bus.i_rs2 = 32'd3; bus.i_rd = 5'd9;
        bus.i_start = 1'b1;
        wait_cycles(1);
        bus.i_start = 1'b0;
        wait_cycles(10);
        bus.i_flush = 1'b1;
        wait_cycles(1);
        bus.i_flush = 1'b0;
        check("flush_valid", 32'(bus.o_valid), 32'd0);
        check("flush_ready", 32'(bus.o_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.o_valid) seen++;
            wait_cycles(1);
        end
        check("flush_no_valid", 32'(seen), 32'd0);
        run_op(3'd5, 32'd100, 32'd7, 5'd3, res, rd_o, lat);
        check("post_flush_divu", res, 32'd14);

        // Backpressure in DONE, with start pulses while busy ignored
        wait_cycles(1);
        bus.i_res_ready = 1'b0;
        run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, res, rd_o, lat);
        // run_op returns at the first valid cycle; inject a busy-time start in the next check window
        held = ref_result(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        check("bp_first_result", res, held);
        for (int k = 0; k < 5; k++) begin
            bus.i_op = 3'd0; bus.i_rs1 = 32'd3; bus.i_rs2 = 32'd5; bus.i_rd = 5'd1;
            bus.i_start = (k % 2 == 0);
            wait_cycles(1);
            check($sformatf("bp_hold%0d_valid", k), 32'(bus.o_valid), 32'd1);
            check($sformatf("bp_hold%0d_result", k), bus.o_result, held);
            check($sformatf("bp_hold%0d_rd", k), 32'(bus.o_rd), 32'd21);
        end
        bus.i_start = 1'b0;
        bus.i_res_ready = 1'b1;
        wait_cycles(1);
        check("bp_release_valid", 32'(bus.o_valid), 32'd0);
        check("bp_release_ready", 32'(bus.o_ready), 32'd1);

        // Start pulse during CALC is ignored and the original op completes
        run_op(3'd7, 32'd1000, 32'd0, 5'd2, res, rd_o, lat);  // leaves a nonzero REMU result
        wait_cycles(1);
        bus.i_op = 3'd6; bus.i_rs1 = 32'd100; bus.i_rs2 = 32'd7; bus.i_rd = 5'd4;
        bus.i_start = 1'b1;
        wait_cycles(1);
        bus.i_start = 1'b0;
        wait_cycles(5);
        bus.i_op = 3'd0; bus.i_rs1 = 32'd9; bus.i_rs2 = 32'd9; bus.i_rd = 5'd30;
        bus.i_start = 1'b1;
        wait_cycles(1);
        bus.i_start = 1'b0;
        lat = 7;
        while (!bus.o_valid && lat < 100) begin
            wait_cycles(1);
            lat++;
        end
        check("busy_start_ignored_result", bus.o_result, 32'd2);
        check("busy_start_ignored_rd", 32'(bus.o_rd), 32'd4);
        check("busy_start_ignored_latency", 32'(lat), 32'd34);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            wait_cycles(1);
            if (bus.o_valid) seen++;
        end
        check("busy_start_no_second_result", 32'(seen), 32'd0);

        // Asynchronous reset mid-CALC: outputs clear before the next edge
        bus.i_op = 3'd1; bus.i_rs1 = 32'hDEAD_BEEF; bus.i_rs2 = 32'h0000_1234; bus.i_rd = 5'd17;
        bus.i_start = 1'b1;
        wait_cycles(1);
        bus.i_start = 1'b0;
        wait_cycles(10);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready",  32'(bus.o_ready), 32'd1);
        check("arst_busy",   32'(bus.o_busy),  32'd0);
        check("arst_valid",  32'(bus.o_valid), 32'd0);
        check("arst_result", bus.o_result,     32'd0);
        check("arst_rd",     32'(bus.o_rd),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd0, 32'd3, 32'd5, 5'd31, res, rd_o, lat);
        check("post_rst_mul", res, 32'd15);
        check("post_rst_rd", 32'(rd_o), 32'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
